tdm_demux_4ch: RTL and testbench



---
 rtl/tdm_demux_4ch.sv | 143 ++++++++++++++
 tb/tb_tdm_demux_4ch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive end of a 4-slot TDM lane; aligns on in_sof and steers slot n to channel n.
// Latency: every output is registered, one cycle after the accepted beat. Backpressure: none (in_valid gaps stall the frame).
// Optional macro TDM_DEMUX_FRAME_ALIGN_EN: buffer slots in shadow registers and publish y0..y3 together on frame_done.
module tdm_demux_4ch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  output logic         frame_done,
  output logic         sync_err,
  output logic         locked
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [3:0][W-1:0]   y_q, y_d;
  logic [3:0]          v_q, v_d;
  logic                fd_q, fd_d;
  logic                se_q, se_d;

  // Accepted-beat decode shared by the capture logic below.
  logic                cap;
  logic [1:0]          cap_slot;

`ifdef TDM_DEMUX_FRAME_ALIGN_EN
  // Slots 0..2 of the frame in flight; slot 3 comes straight from the lane at commit.
  logic [2:0][W-1:0]   sh_q, sh_d;
`endif

  // Next-state, slot tracking, capture steering and pulse generation.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    y_d      = y_q;
    v_d      = '0;
    fd_d     = 1'b0;
    se_d     = 1'b0;
    cap      = 1'b0;
    cap_slot = 2'd0;
`ifdef TDM_DEMUX_FRAME_ALIGN_EN
    sh_d     = sh_q;
`endif

    if (in_valid) begin
      if (state_q == ST_HUNT) begin
        // Only an SOF beat can open a frame; everything else is dropped.
        if (in_sof) begin
          cap     = 1'b1;
          state_d = ST_LOCKED;
        end
      end else if (in_sof) begin
        // SOF away from slot 0 abandons the partial frame and restarts at slot 0.
        se_d = (slot_q != 2'd0);
        cap  = 1'b1;
      end else if (slot_q == 2'd0) begin
        // Expected an SOF but got a plain beat: alignment lost.
        se_d    = 1'b1;
        state_d = ST_HUNT;
      end else begin
        cap      = 1'b1;
        cap_slot = slot_q;
      end
    end

    if (cap) begin
      slot_d = cap_slot + 2'd1;
      fd_d   = (cap_slot == 2'd3);
`ifdef TDM_DEMUX_FRAME_ALIGN_EN
      case (cap_slot)
        2'd0:    sh_d[0] = in_data;
        2'd1:    sh_d[1] = in_data;
        2'd2:    sh_d[2] = in_data;
        default: begin
          y_d = {in_data, sh_q[2], sh_q[1], sh_q[0]};
          v_d = 4'hF;
        end
      endcase
`else
      y_d[cap_slot] = in_data;
      v_d[cap_slot] = 1'b1;
`endif
    end
  end

  // State and output registers; reset discards any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      slot_q  <= 2'd0;
      y_q     <= '0;
      v_q     <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      y_q     <= y_d;
      v_q     <= v_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

`ifdef TDM_DEMUX_FRAME_ALIGN_EN
  // Shadow frame buffer; contents of an abandoned frame are simply overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end
`endif

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign v0         = v_q[0];
  assign v1         = v_q[1];
  assign v2         = v_q[2];
  assign v3         = v_q[3];
  assign frame_done = fd_q;
  assign sync_err   = se_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed frames plus random frames against a queue-based frame model.
// Expected outputs are queued per driven cycle and checked by an independent monitor.
// Honours TDM_DEMUX_FRAME_ALIGN_EN in the model when the design is built with it.
module tb_tdm_demux_4ch;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] in_data;
  logic [W-1:0] y0, y1, y2, y3;
  logic         v0, v1, v2, v3;
  logic         frame_done, sync_err, locked;

  tdm_demux_4ch #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .frame_done(frame_done), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] y;
    logic [3:0]        v;
    logic              fd;
    logic              se;
    logic              lk;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a frame is the list of words collected since the last SOF.
  bit                m_lock;
  logic [W-1:0]      m_buf[$];
  logic [3:0][W-1:0] m_y;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_buf.delete();
    m_y    = '0;
  endtask

  task automatic model_step(input bit vld, input bit sof, input logic [W-1:0] d);
    exp_t e;
    bit   take;
    int   n;
    e    = '0;
    take = 1'b0;
    if (vld) begin
      if (sof) begin
        if (m_lock && m_buf.size() != 0) e.se = 1'b1;
        m_buf.delete();
        m_lock = 1'b1;
        take   = 1'b1;
      end else if (m_lock) begin
        if (m_buf.size() == 0) begin
          e.se   = 1'b1;
          m_lock = 1'b0;
        end else begin
          take = 1'b1;
        end
      end
    end
    if (take) begin
      m_buf.push_back(d);
      n = m_buf.size() - 1;
`ifdef TDM_DEMUX_FRAME_ALIGN_EN
      if (m_buf.size() == 4) begin
        for (int k = 0; k < 4; k++) m_y[k] = m_buf[k];
        e.v = 4'hF;
      end
`else
      m_y[n] = d;
      e.v[n] = 1'b1;
`endif
      if (m_buf.size() == 4) begin
        e.fd = 1'b1;
        m_buf.delete();
      end
    end
    e.y  = m_y;
    e.lk = m_lock;
    q.push_back(e);
  endtask

  task automatic beat(input bit vld, input bit sof, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = vld;
    in_sof   = sof;
    in_data  = d;
    model_step(vld, sof, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic frame4(input logic [W-1:0] a, b, c, d);
    beat(1'b1, 1'b1, a);
    beat(1'b1, 1'b0, b);
    beat(1'b1, 1'b0, c);
    beat(1'b1, 1'b0, d);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_y"}, {y3, y2, y1, y0}, 32'h0);
    chk({nm, "_flags"}, {25'h0, v3, v2, v1, v0, frame_done, sync_err, locked}, 32'h0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input int ncyc);
    @(negedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk_zero("async_rst");
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares the registered outputs after every edge that has a queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("y", {y3, y2, y1, y0}, e.y);
      chk("pulses", {26'h0, v3, v2, v1, v0, frame_done, sync_err}, {26'h0, e.v, e.fd, e.se});
      chk("locked", {31'h0, locked}, {31'h0, e.lk});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // HUNT drops beats without SOF.
    beat(1'b1, 1'b0, 8'hA1);
    beat(1'b1, 1'b0, 8'hA2);

    // Two clean frames back to back.
    frame4(8'h11, 8'h22, 8'h33, 8'h44);
    frame4(8'h55, 8'h66, 8'h77, 8'h88);

    // Stall between slot 1 and slot 2.
    beat(1'b1, 1'b1, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b0, 1'b1, 8'hEE);
    beat(1'b0, 1'b0, 8'hEF);
    beat(1'b1, 1'b0, 8'h03);
    beat(1'b1, 1'b0, 8'h04);

    // Early SOF abandons the partial frame.
    beat(1'b1, 1'b1, 8'h10);
    beat(1'b1, 1'b0, 8'h20);
    frame4(8'hA0, 8'hB0, 8'hC0, 8'hD0);

    // Missing SOF drops the beat and loses lock, next SOF relocks.
    frame4(8'h31, 8'h32, 8'h33, 8'h34);
    beat(1'b1, 1'b0, 8'h99);
    beat(1'b1, 1'b0, 8'h9A);
    frame4(8'h41, 8'h42, 8'h43, 8'h44);

    // Reset mid-frame, then unaligned beats must be dropped.
    beat(1'b1, 1'b1, 8'hE1);
    beat(1'b1, 1'b0, 8'hE2);
    idle(1);
    async_reset(2);
    beat(1'b1, 1'b0, 8'hE3);
    beat(1'b1, 1'b0, 8'hE4);
    frame4(8'hF1, 8'hF2, 8'hF3, 8'hF4);

    // Random frames of length 1..5 (short = early SOF, long = missing SOF) with random stalls.
    for (int f = 0; f < 300; f++) begin
      len = $urandom_range(1, 5);
      if (len == 5 && $urandom_range(0, 1) == 1) len = 4;
      for (int s = 0; s < len; s++) begin
        while ($urandom_range(0, 3) == 0) idle(1);
        beat(1'b1, s == 0, W'($urandom));
      end
      if (f % 97 == 50) async_reset(1);
    end

    idle(2);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
